// File: rtl/mill_mod_pkg.sv
// Shared types and constants for the Modified Miller receiver.
package mill_mod_pkg;

    typedef enum logic [1:0] {
        SLOT_X,
        SLOT_Y,
        SLOT_Z
    } slot_e;

    typedef enum logic {
        IDLE,
        RX
    } state_e;

    localparam logic [1:0] RATE_106 = 2'd0;
    localparam logic [1:0] RATE_212 = 2'd1;
    localparam logic [1:0] RATE_424 = 2'd2;
    localparam logic [1:0] RATE_848 = 2'd3;

    localparam int ETU_BASE_DEF = 32;

endpackage

// File: rtl/mill_etu_cnt.sv
// ETU position counter: hold-at-zero, realign load, and wrap at etu-1.
module mill_etu_cnt #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic [CNT_W-1:0] etu,
    output logic [CNT_W-1:0] cnt,
    output logic             wrap
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    assign wrap = (cnt == etu - ONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (wrap) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + ONE;
        end
    end

endmodule

// File: rtl/miller_mod_rx.sv
// Modified Miller (ISO 14443-A PCD->PICC) decoder: pause timing -> X/Y/Z slots -> NRZ bits.
// state | meaning
// IDLE  | waiting for SOF pause; counter held at 0, rate follows in_rate
// RX    | frame in progress; slots classified at each slot end
module miller_mod_rx
    import mill_mod_pkg::*;
#(
    parameter int ETU_BASE = ETU_BASE_DEF,
    parameter int CNT_W    = 6,
    parameter int TOL      = 2,
    parameter int NBITS_W  = 12
) (
    input  logic               clk,
    input  logic               in_PoR,
    input  logic               in_pause,
    input  logic [1:0]         in_rate,
    output logic               out_data,
    output logic               out_valid,
    output logic               out_sof,
    output logic               out_eof,
    output logic               out_err,
    output logic [NBITS_W-1:0] out_nbits
);

    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] ETU_V = CNT_W'(ETU_BASE);
    localparam logic [CNT_W-1:0] TOL_V = CNT_W'(TOL);

    state_e           state_q, state_n;
    slot_e            prev_q, prev_n, cls;
    logic             hold_q, hold_n, hold_v_q, hold_v_n;
    logic             pz_q, pz_n, px_q, px_n, first_q, first_n;
    logic [1:0]       rate_q;
    logic             pause_q;
    logic [CNT_W-1:0] run_q;
    logic             emit_n, sof_n, eof_n, err_n;
    logic             cnt_clr, cnt_load;
    logic [CNT_W-1:0] cnt_val, cnt, etu, half, tol;
    logic             wrap, pstart, long_pause;
    logic             z_early, z_late, x_hit, bad_pos, dup, slot_end;

    assign etu  = ETU_V >> rate_q;
    assign half = etu >> 1;
    assign tol  = TOL_V >> rate_q;

    assign pstart     = in_pause & ~pause_q;
    assign long_pause = in_pause && (run_q == etu - ONE);

    // A late pause belongs to the next slot and closes the current one early.
    assign z_late   = pstart && (cnt >= etu - tol);
    assign z_early  = pstart && !z_late && (cnt <= tol);
    assign x_hit    = pstart && !z_late && !z_early && (cnt >= half - tol) && (cnt <= half + tol);
    assign bad_pos  = pstart && !(z_early || z_late || x_hit);
    assign dup      = (z_early || x_hit) && (pz_q || px_q);
    assign slot_end = wrap || z_late;
    assign cls      = px_q ? SLOT_X : (pz_q ? SLOT_Z : SLOT_Y);

    mill_etu_cnt #(.CNT_W(CNT_W)) u_etu_cnt (
        .clk      (clk),
        .rst      (in_PoR),
        .clr      (cnt_clr),
        .load     (cnt_load),
        .load_val (cnt_val),
        .etu      (etu),
        .cnt      (cnt),
        .wrap     (wrap)
    );

    always_comb begin
        state_n  = state_q;
        prev_n   = prev_q;
        hold_n   = hold_q;
        hold_v_n = hold_v_q;
        pz_n     = pz_q;
        px_n     = px_q;
        first_n  = first_q;
        emit_n   = 1'b0;
        sof_n    = 1'b0;
        eof_n    = 1'b0;
        err_n    = 1'b0;
        cnt_clr  = 1'b0;
        cnt_load = 1'b0;
        cnt_val  = '0;
        case (state_q)
            IDLE: begin
                cnt_clr = 1'b1;
                if (pstart) begin
                    sof_n    = 1'b1;
                    state_n  = RX;
                    cnt_clr  = 1'b0;
                    cnt_load = 1'b1;
                    cnt_val  = ONE;
                    prev_n   = SLOT_Z;
                    hold_n   = 1'b0;
                    hold_v_n = 1'b0;
                    pz_n     = 1'b1;
                    px_n     = 1'b0;
                    first_n  = 1'b1;
                end
            end
            RX: begin
                if (long_pause || bad_pos || dup) begin
                    err_n    = 1'b1;
                    state_n  = IDLE;
                    cnt_clr  = 1'b1;
                    hold_v_n = 1'b0;
                end else begin
                    // The pause cycle itself becomes count 0 (Z) or count half (X).
                    if (z_early) begin
                        pz_n     = 1'b1;
                        cnt_load = 1'b1;
                        cnt_val  = ONE;
                    end
                    if (x_hit) begin
                        px_n     = 1'b1;
                        cnt_load = 1'b1;
                        cnt_val  = half + ONE;
                    end
                    if (slot_end) begin
                        pz_n    = z_late;
                        px_n    = 1'b0;
                        first_n = 1'b0;
                        if (z_late) begin
                            cnt_load = 1'b1;
                            cnt_val  = ONE;
                        end
                        // The SOF slot is already accounted for by prev = Z.
                        if (!first_q) begin
                            prev_n = cls;
                            case (cls)
                                SLOT_X: begin
                                    emit_n   = hold_v_q;
                                    hold_n   = 1'b1;
                                    hold_v_n = 1'b1;
                                end
                                SLOT_Z: begin
                                    if (prev_q == SLOT_X) begin
                                        err_n    = 1'b1;
                                        state_n  = IDLE;
                                        cnt_clr  = 1'b1;
                                        hold_v_n = 1'b0;
                                    end else begin
                                        emit_n   = hold_v_q;
                                        hold_n   = 1'b0;
                                        hold_v_n = 1'b1;
                                    end
                                end
                                default: begin
                                    if (prev_q == SLOT_X) begin
                                        emit_n   = hold_v_q;
                                        hold_n   = 1'b0;
                                        hold_v_n = 1'b1;
                                    end else begin
                                        eof_n    = 1'b1;
                                        state_n  = IDLE;
                                        cnt_clr  = 1'b1;
                                        hold_v_n = 1'b0;
                                    end
                                end
                            endcase
                        end
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (in_PoR) begin
            state_q   <= IDLE;
            prev_q    <= SLOT_Z;
            hold_q    <= 1'b0;
            hold_v_q  <= 1'b0;
            pz_q      <= 1'b0;
            px_q      <= 1'b0;
            first_q   <= 1'b0;
            rate_q    <= RATE_106;
            pause_q   <= 1'b0;
            run_q     <= '0;
            out_data  <= 1'b0;
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_eof   <= 1'b0;
            out_err   <= 1'b0;
            out_nbits <= '0;
        end else begin
            state_q   <= state_n;
            prev_q    <= prev_n;
            hold_q    <= hold_n;
            hold_v_q  <= hold_v_n;
            pz_q      <= pz_n;
            px_q      <= px_n;
            first_q   <= first_n;
            pause_q   <= in_pause;
            if (!in_pause) begin
                run_q <= '0;
            end else if (run_q != '1) begin
                run_q <= run_q + ONE;
            end
            if (state_q == IDLE) begin
                rate_q <= in_rate;
            end
            out_valid <= emit_n;
            if (emit_n) begin
                out_data <= hold_q;
            end
            out_sof <= sof_n;
            out_eof <= eof_n;
            out_err <= err_n;
            if (sof_n) begin
                out_nbits <= '0;
            end else if (emit_n && (out_nbits != '1)) begin
                out_nbits <= out_nbits + NBITS_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_miller_mod_rx.sv
// Bench for miller_mod_rx: pause waveforms built from slot schedules, decoded bits
// compared with the data that was Miller-encoded into them.
module tb_miller_mod_rx;

    localparam int NONE = 1000;
    localparam int LEAD = 4;

    logic        clk = 1'b0;
    logic        in_PoR = 1'b1;
    logic        in_pause = 1'b0;
    logic [1:0]  in_rate = 2'd0;
    logic        out_data, out_valid, out_sof, out_eof, out_err;
    logic [11:0] out_nbits;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    bit got_bits[$];
    int n_sof, n_eof, n_err, sof_cyc, first_v_cyc;
    int sched[$];
    int widths[$];

    miller_mod_rx dut (
        .clk       (clk),
        .in_PoR    (in_PoR),
        .in_pause  (in_pause),
        .in_rate   (in_rate),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_sof   (out_sof),
        .out_eof   (out_eof),
        .out_err   (out_err),
        .out_nbits (out_nbits)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (out_valid) begin
            if (got_bits.size() == 0) first_v_cyc = cyc;
            got_bits.push_back(out_data);
        end
        if (out_sof) begin
            n_sof++;
            sof_cyc = cyc;
        end
        if (out_eof) n_eof++;
        if (out_err) n_err++;
        if (out_sof || out_eof || out_err || out_valid) begin
            checks++;
            if ((int'(out_sof) + int'(out_eof) + int'(out_err) > 1) || (out_eof && out_valid)) begin
                errors++;
                $display("FAIL strobe_excl: sof=%0b eof=%0b err=%0b valid=%0b, required one strobe and no eof with valid",
                         out_sof, out_eof, out_err, out_valid);
            end
        end
    end

    function automatic logic [31:0] pack(input bit q[$]);
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < q.size() && i < 32; i++) v[i] = q[i];
        return v;
    endfunction

    // Drives one schedule: per slot a pause offset from the slot start (NONE = no pause,
    // negative = late Z of that slot). The slot grid follows the receiver's realignment.
    task automatic run_frame(input int rate, input int rst_at);
        int etu, half, tol, shift, t, pw, len, o;
        logic wave [0:4095];
        etu = 32 >> rate;
        half = etu / 2;
        tol = 2 >> rate;
        for (int i = 0; i < 4096; i++) wave[i] = 1'b0;
        shift = 0;
        for (int k = 0; k < sched.size(); k++) begin
            o = sched[k];
            if (o != NONE) begin
                t = LEAD + k * etu + shift + o;
                if (k < widths.size() && widths[k] != 0) pw = widths[k];
                else pw = int'($urandom_range(half / 2, 1));
                for (int j = 0; j < pw; j++) wave[t + j] = 1'b1;
                if (o >= half - tol && o <= half + tol) shift += o - half;
                else shift += o;
            end
        end
        len = LEAD + sched.size() * etu + shift + 2 * etu + 8;
        got_bits.delete();
        n_sof = 0; n_eof = 0; n_err = 0; sof_cyc = 0; first_v_cyc = 0;
        in_rate = 2'(rate);
        for (int i = 0; i < len; i++) begin
            in_pause = wave[i] && !(rst_at >= 0 && i >= rst_at);
            in_PoR = (rst_at >= 0) && (i == rst_at || i == rst_at + 1);
            @(posedge clk); #1;
            if (rst_at >= 0 && i == rst_at) begin
                checks++;
                if ({out_data, out_valid, out_sof, out_eof, out_err} !== 5'b0 || out_nbits !== 12'd0) begin
                    errors++;
                    $display("FAIL rst_mid_outputs: got d/v/s/e/r=%b nbits=%0d, required all 0",
                             {out_data, out_valid, out_sof, out_eof, out_err}, out_nbits);
                end
            end
        end
        in_pause = 1'b0;
        in_PoR = 1'b0;
        widths.delete();
    endtask

    task automatic test_reset();
        in_PoR = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({out_data, out_valid, out_sof, out_eof, out_err} !== 5'b0) begin
            errors++;
            $display("FAIL reset_strobes: got %b, required 00000", {out_data, out_valid, out_sof, out_eof, out_err});
        end
        checks++;
        if (out_nbits !== 12'd0) begin
            errors++;
            $display("FAIL reset_nbits: got %0d, required 0", out_nbits);
        end
        in_PoR = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        sched = '{0, 16, NONE, 16, 16, NONE, NONE};
        run_frame(0, -1);
        checks++;
        if (n_sof !== 1) begin errors++; $display("FAIL basic_sof: got %0d, required 1", n_sof); end
        checks++;
        if (got_bits.size() !== 4 || pack(got_bits) !== 32'b1101) begin
            errors++;
            $display("FAIL basic_bits: got n=%0d v=%b, required n=4 v=1101", got_bits.size(), pack(got_bits));
        end
        checks++;
        if (n_eof !== 1 || n_err !== 0) begin
            errors++; $display("FAIL basic_eof: got eof=%0d err=%0d, required 1/0", n_eof, n_err);
        end
        checks++;
        if (out_nbits !== 12'd4) begin errors++; $display("FAIL basic_nbits: got %0d, required 4", out_nbits); end
        checks++;
        if (first_v_cyc - sof_cyc !== 95) begin
            errors++; $display("FAIL basic_latency: got %0d, required 95", first_v_cyc - sof_cyc);
        end
    endtask

    task automatic test_zeros();
        sched = '{0, 0, 0, 0, NONE};
        run_frame(0, -1);
        checks++;
        if (got_bits.size() !== 2 || pack(got_bits) !== 32'b0) begin
            errors++;
            $display("FAIL zeros_bits: got n=%0d v=%b, required n=2 v=00", got_bits.size(), pack(got_bits));
        end
        checks++;
        if (n_eof !== 1 || out_nbits !== 12'd2) begin
            errors++; $display("FAIL zeros_eof: got eof=%0d nbits=%0d, required 1/2", n_eof, out_nbits);
        end
    endtask

    task automatic test_zx_error();
        sched = '{0, 16, 0};
        run_frame(0, -1);
        checks++;
        if (n_err !== 1 || n_eof !== 0 || got_bits.size() !== 0 || out_nbits !== 12'd0) begin
            errors++;
            $display("FAIL zx_err: got err=%0d eof=%0d bits=%0d nbits=%0d, required 1/0/0/0",
                     n_err, n_eof, got_bits.size(), out_nbits);
        end
        sched = '{0, 16, NONE, NONE};
        run_frame(0, -1);
        checks++;
        if (n_sof !== 1 || got_bits.size() !== 1 || pack(got_bits) !== 32'b1 || n_eof !== 1 || out_nbits !== 12'd1) begin
            errors++;
            $display("FAIL zx_recover: got sof=%0d n=%0d v=%b eof=%0d nbits=%0d, required 1/1/1/1/1",
                     n_sof, got_bits.size(), pack(got_bits), n_eof, out_nbits);
        end
    endtask

    task automatic test_tolerance();
        sched = '{0, 17, NONE, -2, 2, 15, NONE, NONE};
        run_frame(0, -1);
        checks++;
        if (got_bits.size() !== 5 || pack(got_bits) !== 32'b10001 || n_err !== 0) begin
            errors++;
            $display("FAIL tol_bits: got n=%0d v=%b err=%0d, required n=5 v=10001 err=0",
                     got_bits.size(), pack(got_bits), n_err);
        end
        checks++;
        if (n_eof !== 1 || out_nbits !== 12'd5) begin
            errors++; $display("FAIL tol_eof: got eof=%0d nbits=%0d, required 1/5", n_eof, out_nbits);
        end
        sched = '{0, 10};
        run_frame(0, -1);
        checks++;
        if (n_sof !== 1 || n_err !== 1 || n_eof !== 0 || got_bits.size() !== 0) begin
            errors++;
            $display("FAIL tol_offset10: got sof=%0d err=%0d eof=%0d bits=%0d, required 1/1/0/0",
                     n_sof, n_err, n_eof, got_bits.size());
        end
    endtask

    task automatic test_rate1();
        sched = '{0, 8, NONE, 8, 8, NONE, NONE};
        run_frame(1, -1);
        checks++;
        if (got_bits.size() !== 4 || pack(got_bits) !== 32'b1101 || n_eof !== 1 || out_nbits !== 12'd4) begin
            errors++;
            $display("FAIL rate1: got n=%0d v=%b eof=%0d nbits=%0d, required 4/1101/1/4",
                     got_bits.size(), pack(got_bits), n_eof, out_nbits);
        end
    endtask

    task automatic test_long_pause();
        sched = '{0, NONE, NONE};
        widths = '{31};
        run_frame(0, -1);
        checks++;
        if (n_err !== 0 || n_eof !== 1) begin
            errors++; $display("FAIL pause31: got err=%0d eof=%0d, required 0/1", n_err, n_eof);
        end
        sched = '{0};
        widths = '{32};
        run_frame(0, -1);
        checks++;
        if (n_err !== 1 || n_eof !== 0 || out_nbits !== 12'd0) begin
            errors++;
            $display("FAIL pause32: got err=%0d eof=%0d nbits=%0d, required 1/0/0", n_err, n_eof, out_nbits);
        end
    endtask

    task automatic test_reset_mid();
        sched = '{0, 16, NONE, 16, 16, NONE, NONE};
        run_frame(0, LEAD + 3 * 32 + 5);
        checks++;
        if (n_eof !== 0 || n_err !== 0 || out_nbits !== 12'd0) begin
            errors++;
            $display("FAIL rst_mid_silent: got eof=%0d err=%0d nbits=%0d, required 0/0/0", n_eof, n_err, out_nbits);
        end
        sched = '{0, 16, NONE, 16, 16, NONE, NONE};
        run_frame(0, -1);
        checks++;
        if (got_bits.size() !== 4 || pack(got_bits) !== 32'b1101 || n_eof !== 1 || out_nbits !== 12'd4) begin
            errors++;
            $display("FAIL rst_mid_next: got n=%0d v=%b eof=%0d nbits=%0d, required 4/1101/1/4",
                     got_bits.size(), pack(got_bits), n_eof, out_nbits);
        end
    endtask

    // Random data, Miller-encoded: 1 -> X, 0 -> Y after a 1 else Z; EOF = logic 0 then Y.
    task automatic test_random();
        bit src[$];
        int n, rate, half;
        bit prev_one;
        for (int f = 0; f < 8; f++) begin
            rate = int'($urandom_range(3, 0));
            half = (32 >> rate) / 2;
            n = int'($urandom_range(12, 1));
            src.delete();
            sched.delete();
            sched.push_back(0);
            prev_one = 1'b0;
            for (int i = 0; i < n; i++) begin
                src.push_back(1'($urandom_range(1, 0)));
                if (src[i]) sched.push_back(half);
                else if (prev_one) sched.push_back(NONE);
                else sched.push_back(0);
                prev_one = src[i];
            end
            sched.push_back(prev_one ? NONE : 0);
            sched.push_back(NONE);
            run_frame(rate, -1);
            checks++;
            if (got_bits.size() !== n || pack(got_bits) !== pack(src)) begin
                errors++;
                $display("FAIL rand_bits[%0d]: rate=%0d got n=%0d v=%b, required n=%0d v=%b",
                         f, rate, got_bits.size(), pack(got_bits), n, pack(src));
            end
            checks++;
            if (n_sof !== 1 || n_eof !== 1 || n_err !== 0 || out_nbits !== 12'(n)) begin
                errors++;
                $display("FAIL rand_frame[%0d]: got sof=%0d eof=%0d err=%0d nbits=%0d, required 1/1/0/%0d",
                         f, n_sof, n_eof, n_err, out_nbits, n);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zeros();
        test_zx_error();
        test_tolerance();
        test_rate1();
        test_long_pause();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/miller_mod_rx.md
MILLER_MOD_RX -- requirements
Module: miller_mod_rx

Interface
REQ-001 Parameter ETU_BASE, default 32: clocks per ETU at 106 kbit/s (fc/4 clock).
REQ-002 Parameter CNT_W, default 6: ETU counter width; SHALL satisfy 2**CNT_W > ETU_BASE.
REQ-003 Parameter TOL, default 2: pause-start position tolerance in clocks at rate 0.
REQ-004 Parameter NBITS_W, default 12: received-bit counter width.
REQ-005 clk  input  1  single clock (fc/4, 3.39 MHz); all logic on rising edge.
REQ-006 in_PoR  input  1  synchronous, active-high reset.
REQ-007 in_pause  input  1  pause-detector output, synchronous to clk; 1 = carrier paused.
REQ-008 in_rate  input  2  bit-rate select: 0/1/2/3 = 106/212/424/848 kbit/s.
REQ-009 out_data  output  1  decoded NRZ-L bit, qualified by out_valid.
REQ-010 out_valid  output  1  one-cycle strobe per decoded data bit.
REQ-011 out_sof  output  1  one-cycle strobe on start-of-frame.
REQ-012 out_eof  output  1  one-cycle strobe on valid end-of-frame.
REQ-013 out_err  output  1  one-cycle strobe on coding/timing violation.
REQ-014 out_nbits  output  NBITS_W  data bits emitted in the current or last frame.

Function
REQ-015 ETU length etu = ETU_BASE >> in_rate; half = etu/2; tolerance tol = TOL >> in_rate; in_rate SHALL be latched only in IDLE.
REQ-016 Pause start = in_pause high while its registered copy is low (one-cycle edge detect).
REQ-017 States: IDLE, RX. IDLE: counter held at 0; first pause start = SOF (sequence Z) -> pulse out_sof, clear out_nbits, counter <= 1, prev slot <= Z, hold buffer empty, go RX.
REQ-018 RX: counter increments each cycle, wraps to 0 after etu-1 (slot end).
REQ-019 Pause start at count 0..tol or etu-tol..etu-1 (next slot) marks Z and realigns counter to 0 (or 1 if the start falls on the wrap cycle); at half-tol..half+tol marks X and realigns counter to half.
REQ-020 Pause start at any other count, a second pause start in one slot, or in_pause high for etu consecutive cycles -> out_err pulse, go IDLE.
REQ-021 At slot end the slot is classified X (pause at half), Z (pause at start), or Y (no pause).
REQ-022 Z after X -> out_err, go IDLE.
REQ-023 One-bit hold buffer: X -> emit held bit if valid, hold <= 1; Z, or Y after X -> emit held bit if valid, hold <= 0.
REQ-024 Y after Y or Z = EOF: held bit discarded (EOF '0'), out_eof pulses, go IDLE.
REQ-025 Emitted bit: out_data/out_valid asserted the cycle after the slot-end cycle; out_nbits increments with each out_valid and saturates at all-ones.
REQ-026 out_data holds its last value between strobes; out_nbits holds after EOF/error until next SOF.
REQ-027 Strobes are mutually exclusive except out_valid; out_eof never coincides with out_valid.

Reset
REQ-028 in_PoR high: state IDLE, counter 0, hold empty, all outputs 0, out_nbits 0, latched rate 0.
REQ-029 Reset mid-frame aborts silently: no out_eof, no out_err.
REQ-030 in_PoR has priority over every other event in the same cycle.

Structure
REQ-031 Package mill_mod_pkg SHALL hold the slot enum (SLOT_X, SLOT_Y, SLOT_Z), state enum (IDLE, RX), rate encoding constants, and ETU_BASE default.
REQ-032 ETU counter with realign/wrap SHALL be sub-module mill_etu_cnt; slot classification, hold buffer and FSM stay in miller_mod_rx.

Verification
REQ-033 Rate 0 (etu 32, half 16): pause starts at slot offsets 0,16,-,16,16,-,- -> out_sof; bits 1,0,1,1; out_eof; out_nbits = 4.
REQ-034 Rate 0: slots Z,Z,Z,Z,Y -> bits 0,0; out_eof; out_nbits = 2.
REQ-035 Rate 0: SOF, X, then Z -> one bit 1 not emitted, out_err pulse, state IDLE; next Z starts new frame with out_sof.
REQ-036 Rate 0: pause start at offset 17 accepted as X; at offset 10 -> out_err.
REQ-037 Rate 1 (etu 16, half 8, tol 1): pattern of REQ-033 scaled -> identical bits, out_nbits = 4.
REQ-038 in_PoR pulsed during slot 3 of REQ-033 frame -> all outputs 0, no out_eof/out_err; subsequent frame decodes normally.
